// File: rtl/gen_rr_arbiter.sv
// Round-robin arbiter with hold-limit preemption and a one-cycle PREEMPT gap.
// Optional per-requester starvation flag when GEN_ARB_STARVE_EN is defined.
module gen_rr_arbiter #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned MAX_HOLD   = 4,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic                    gnt_valid,
    output logic [$clog2(NREQ)-1:0] gnt_idx
`ifdef GEN_ARB_STARVE_EN
    ,
    output logic                    starve
`endif
);

    localparam int unsigned IDX_W  = $clog2(NREQ);
    localparam int unsigned HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_PREEMPT = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_last;
    logic [HOLD_W-1:0] r_hold;

    logic [IDX_W-1:0]  w_base;
    logic [IDX_W-1:0]  w_win_idx;
    logic              w_win_found;
    logic              w_others;
    logic              w_hold_hit;
    logic [NREQ-1:0]   w_win_onehot;

    // Search begins one past the base so the base requester is considered last.
    always_comb begin
        w_base      = (r_state == S_GRANT) ? gnt_idx : r_last;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((32'(w_base) + i) % NREQ);
            if (!w_win_found && req[cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = cand;
            end
        end
        w_win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
        w_others     = |(req & ~gnt);
        w_hold_hit   = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last    <= IDX_W'(NREQ - 1);
            r_hold    <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_PREEMPT: begin
                    if (w_win_found) begin
                        r_state   <= S_GRANT;
                        r_hold    <= HOLD_W'(1);
                        gnt       <= w_win_onehot;
                        gnt_valid <= 1'b1;
                        gnt_idx   <= w_win_idx;
                    end else begin
                        r_state   <= S_IDLE;
                        r_hold    <= '0;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_idx   <= '0;
                    end
                end
                S_GRANT: begin
                    if (!req[gnt_idx]) begin
                        // Voluntary release wins over a simultaneous hold-limit hit.
                        r_last <= gnt_idx;
                        if (w_win_found) begin
                            r_hold    <= HOLD_W'(1);
                            gnt       <= w_win_onehot;
                            gnt_valid <= 1'b1;
                            gnt_idx   <= w_win_idx;
                        end else begin
                            r_state   <= S_IDLE;
                            r_hold    <= '0;
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            gnt_idx   <= '0;
                        end
                    end else if (w_hold_hit && w_others) begin
                        r_last    <= gnt_idx;
                        r_state   <= S_PREEMPT;
                        r_hold    <= '0;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_idx   <= '0;
                    end else if ((MAX_HOLD != 0) && (r_hold < HOLD_W'(MAX_HOLD))) begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_hold    <= '0;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    gnt_idx   <= '0;
                end
            endcase
        end
    end

`ifdef GEN_ARB_STARVE_EN
    localparam int unsigned WAIT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    logic [WAIT_W-1:0] r_wait     [NREQ];
    logic [WAIT_W-1:0] w_wait_nxt [NREQ];
    logic              w_starve_nxt;

    // Wait counters track cycles spent requesting without ownership.
    always_comb begin
        w_starve_nxt = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i] && !gnt[i]) begin
                w_wait_nxt[i] = (r_wait[i] == WAIT_W'(STARVE_LIM)) ? r_wait[i]
                                                                   : r_wait[i] + WAIT_W'(1);
            end else begin
                w_wait_nxt[i] = '0;
            end
            if (w_wait_nxt[i] == WAIT_W'(STARVE_LIM)) begin
                w_starve_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                r_wait[i] <= '0;
            end
            starve <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                r_wait[i] <= w_wait_nxt[i];
            end
            starve <= w_starve_nxt;
        end
    end
`endif

endmodule

// File: doc/gen_rr_arbiter.md
GEN_RR_ARBITER -- requirements
Module: gen_rr_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requesters; legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 4: maximum grant cycles before preemption; 0 disables preemption.
REQ-003 Parameter STARVE_LIM, default 8: wait-cycle threshold for starvation flag.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req  input  NREQ  per-requester request level; held high while ownership is wanted.
REQ-007 gnt  output  NREQ  registered one-hot grant; all-zero when no owner.
REQ-008 gnt_valid  output  1  high when gnt is non-zero.
REQ-009 gnt_idx  output  clog2(NREQ)  index of current owner; 0 when gnt_valid low.
REQ-010 starve  output  1  starvation flag; present only with GEN_ARB_STARVE_EN.

Function
REQ-011 FSM states: IDLE, GRANT, PREEMPT; IDLE at reset.
REQ-012 IDLE: any req high -> select winner, enter GRANT; gnt asserts the cycle after req is sampled (latency 1).
REQ-013 Winner selection: round-robin, search starting at (last_idx+1) mod NREQ, wrapping; last_idx resets to NREQ-1, so requester 0 has first priority after reset.
REQ-014 GRANT: owner keeps gnt while req[owner] high; hold counter increments each GRANT cycle, saturates at MAX_HOLD.
REQ-015 GRANT, req[owner] low: last_idx <= owner; if other req high, next winner granted on the next cycle (no idle bubble), else gnt clears and FSM enters IDLE.
REQ-016 GRANT, MAX_HOLD>0, hold count == MAX_HOLD, and any other req high: gnt clears next cycle, last_idx <= owner, FSM enters PREEMPT.
REQ-017 PREEMPT: exactly one cycle with gnt all-zero; then rearbitrate as in IDLE, preempted requester considered last.
REQ-018 Hold count reset to 1 on every new grant; hold limit ignored while no other requester is pending.
REQ-019 Owner dropping req in the same cycle the hold limit triggers: treated as voluntary release (REQ-015), no PREEMPT.
REQ-020 Requests raised and dropped while not owner are not latched; a req pulse missed by arbitration is lost.
REQ-021 gnt, gnt_valid, gnt_idx registered and mutually consistent every cycle; never more than one gnt bit high.

Reset
REQ-022 rst high at any clock edge, including mid-grant or in PREEMPT: next cycle gnt=0, gnt_valid=0, gnt_idx=0, starve=0, FSM=IDLE, last_idx=NREQ-1, hold count=0, all wait counters=0.
REQ-023 req sampled during reset is ignored; first arbitration on the first edge with rst low.

Configuration
REQ-024 Macro GEN_ARB_STARVE_EN defined: per-requester wait counter increments each cycle req high and not granted, clears when granted or req low, saturates at STARVE_LIM; starve registered high while any counter == STARVE_LIM.
REQ-025 Macro GEN_ARB_STARVE_EN undefined: no wait counters, no starve port; all other behaviour identical.

Verification
REQ-026 NREQ=2, rst released, req=2'b11 held -> gnt=01 cycle 1, after 4 hold cycles gnt=00 one cycle, then gnt=10; alternation repeats.
REQ-027 req=2'b01 pulse 3 cycles then 0 -> gnt=01 for 3 cycles starting 1 cycle after req, then 00, FSM IDLE, no PREEMPT.
REQ-028 Owner 0 drops req while req[1] high -> gnt switches 01->10 on consecutive cycles, gnt_valid stays high.
REQ-029 MAX_HOLD=0, req=2'b11 for 20 cycles -> gnt=01 all 20 cycles; with GEN_ARB_STARVE_EN, starve rises 8 cycles after requester 1 starts waiting.
REQ-030 rst asserted mid-grant (gnt=10) -> next cycle all outputs 0; after release with req=2'b11, gnt=01 first.
REQ-031 NREQ=4, req=4'b1111 held -> grant order 0,1,2,3,0 with one PREEMPT cycle between each; gnt_idx matches gnt.
